// File: rtl/gate_check_pkg.sv
// Shared types and limits for the gate response checker.
package gate_check_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } chk_state_t;

  localparam int MAX_SETTLE = 15;

endpackage

// File: rtl/gate_response_checker_settle_timer.sv
// Load/decrement counter that times the settle window; expired while the count is zero.
module settle_timer
  import gate_check_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [$clog2(MAX_SETTLE+1)-1:0]   load_val,
  output logic                              expired
);

  localparam int CW = $clog2(MAX_SETTLE + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load wins, otherwise count down to zero and stop there.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {CW{1'b0}}) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/gate_response_checker.sv
// Sweeps every input vector of a small combinational gate, samples its response after a
// settle window and scores it against an expected truth table.
module gate_response_checker #(
  parameter int                    N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = 8'b0000_0001,
  parameter int                    SETTLE   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_IN:0]           err_count,
  output logic [(1<<N_IN)-1:0]    captured,
  output logic [N_IN-1:0]         first_fail_idx,
  output logic                    first_fail_vld
);

  localparam int NV = 1 << N_IN;
  localparam int EW = N_IN + 1;
  localparam int TW = $clog2(gate_check_pkg::MAX_SETTLE + 1);
  localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(NV - 1);
  localparam logic [TW-1:0]   SETTLE_LOAD = (SETTLE == 0) ? {TW{1'b0}} : TW'(SETTLE - 1);

  localparam gate_check_pkg::chk_state_t ST_IDLE   = gate_check_pkg::IDLE;
  localparam gate_check_pkg::chk_state_t ST_APPLY  = gate_check_pkg::APPLY;
  localparam gate_check_pkg::chk_state_t ST_SETTLE = gate_check_pkg::SETTLE;
  localparam gate_check_pkg::chk_state_t ST_SAMPLE = gate_check_pkg::SAMPLE;
  localparam gate_check_pkg::chk_state_t ST_DONE   = gate_check_pkg::DONE;

  gate_check_pkg::chk_state_t state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [EW-1:0]   err_q, err_d;
  logic [NV-1:0]   cap_q, cap_d;
  logic [N_IN-1:0] ffi_q, ffi_d;
  logic            ffv_q, ffv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            tmr_load_s;
  logic            tmr_expired_s;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (SETTLE_LOAD),
    .expired  (tmr_expired_s)
  );

  // Sequencer next state, vector index and scoring datapath.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    cap_d      = cap_q;
    ffi_d      = ffi_q;
    ffv_d      = ffv_q;
    tmr_load_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_APPLY;
          idx_d   = {N_IN{1'b0}};
          err_d   = {EW{1'b0}};
          cap_d   = {NV{1'b0}};
          ffi_d   = {N_IN{1'b0}};
          ffv_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_APPLY: begin
        tmr_load_s = 1'b1;
        if (SETTLE == 0) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_expired_s) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        cap_d[idx_q] = dut_out;
        if (dut_out != EXPECTED[idx_q]) begin
          err_d = err_q + EW'(1);
          if (!ffv_q) begin
            ffi_d = idx_q;
            ffv_d = 1'b1;
          end else begin
            ffv_d = ffv_q;
          end
        end else begin
          err_d = err_q;
        end
        // Terminal compare on the last index; idx never wraps.
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + N_IN'(1);
          state_d = ST_APPLY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are derived from the next state so they register with it.
  always_comb begin
    busy_d = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == {EW{1'b0}});
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= {N_IN{1'b0}};
      err_q   <= {EW{1'b0}};
      cap_q   <= {NV{1'b0}};
      ffi_q   <= {N_IN{1'b0}};
      ffv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cap_q   <= cap_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // idx only moves on entry to APPLY and holds NV-1 in DONE, so it is the driven vector.
  assign dut_in         = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign captured       = cap_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench: two checkers (SETTLE=2 and SETTLE=0) share stimulus; a time-based sweep model
// predicts every output each cycle, plus directed literal expectations.
module tb_gate_response_checker;

  localparam logic [7:0] NOR_TT = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] tt_r;

  logic [2:0] dut_in_s  [2];
  logic       dut_out_s [2];
  logic       busy_s    [2];
  logic       done_s    [2];
  logic       pass_s    [2];
  logic [3:0] err_s     [2];
  logic [7:0] cap_s     [2];
  logic [2:0] ffi_s     [2];
  logic       ffv_s     [2];

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 sweeping (m_k edges since accept), 2 done.
  int         m_ph [2];
  int         m_k  [2];
  logic [7:0] m_tt [2];

  always #5 clk = ~clk;

  // Gate under test is a truth-table lookup chosen by the bench.
  assign dut_out_s[0] = tt_r[dut_in_s[0]];
  assign dut_out_s[1] = tt_r[dut_in_s[1]];

  gate_response_checker #(.N_IN(3), .EXPECTED(NOR_TT), .SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in_s[0]), .dut_out(dut_out_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]),
    .captured(cap_s[0]), .first_fail_idx(ffi_s[0]), .first_fail_vld(ffv_s[0])
  );

  gate_response_checker #(.N_IN(3), .EXPECTED(NOR_TT), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .dut_in(dut_in_s[1]), .dut_out(dut_out_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]),
    .captured(cap_s[1]), .first_fail_idx(ffi_s[1]), .first_fail_vld(ffv_s[1])
  );

  function automatic int plen(input int u);
    return (u == 0) ? 4 : 2;
  endfunction

  // Reference sweep timeline.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        m_ph[u] <= 0;
        m_k[u]  <= 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if ((m_ph[u] != 1) && start) begin
          m_ph[u] <= 1;
          m_k[u]  <= 0;
          m_tt[u] <= tt_r;
        end else if (m_ph[u] == 1) begin
          m_k[u] <= m_k[u] + 1;
          if (m_k[u] + 1 == 8 * plen(u)) m_ph[u] <= 2;
        end
      end
    end
  end

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s unit%0d got %0h expected %0h at %0t", name, u, act, exp, $time);
    end
  endtask

  task automatic compare_unit(input int u);
    int         c;
    int         din;
    int         err;
    int         ffi;
    logic       ffv;
    logic [7:0] cap;
    logic [7:0] exp_tt;
    exp_tt = NOR_TT;
    c = 0; din = 0; err = 0; ffi = 0; ffv = 1'b0; cap = 8'h00;
    if (m_ph[u] == 1) begin
      c   = m_k[u] / plen(u);
      din = c;
    end else if (m_ph[u] == 2) begin
      c   = 8;
      din = 7;
    end
    for (int v = 0; v < c; v++) begin
      cap[v] = m_tt[u][v];
      if (m_tt[u][v] != exp_tt[v]) begin
        if (!ffv) begin
          ffv = 1'b1;
          ffi = v;
        end
        err++;
      end
    end
    chk("busy",      u, 32'(busy_s[u]),   32'(m_ph[u] == 1));
    chk("done",      u, 32'(done_s[u]),   32'(m_ph[u] == 2));
    chk("pass",      u, 32'(pass_s[u]),   32'((m_ph[u] == 2) && (err == 0)));
    chk("dut_in",    u, 32'(dut_in_s[u]), 32'(din));
    chk("err_count", u, 32'(err_s[u]),    32'(err));
    chk("captured",  u, 32'(cap_s[u]),    32'(cap));
    chk("ff_idx",    u, 32'(ffi_s[u]),    32'(ffi));
    chk("ff_vld",    u, 32'(ffv_s[u]),    32'(ffv));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_both_done(input int bound);
    int n;
    n = 0;
    while (!(done_s[0] && done_s[1]) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("both_done", 0, 32'(done_s[0] && done_s[1]), 32'd1);
  endtask

  task automatic expect_cleared(input string tag);
    chk({tag, "_busy"}, 0, 32'(busy_s[0]),   32'd0);
    chk({tag, "_done"}, 0, 32'(done_s[0]),   32'd0);
    chk({tag, "_err"},  0, 32'(err_s[0]),    32'd0);
    chk({tag, "_cap"},  0, 32'(cap_s[0]),    32'd0);
    chk({tag, "_ffv"},  0, 32'(ffv_s[0]),    32'd0);
    chk({tag, "_din"},  0, 32'(dut_in_s[0]), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tt_r  = NOR_TT;
    fork
      forever begin
        @(negedge clk);
        compare_unit(0);
        compare_unit(1);
      end
    join_none
    repeat (2) @(negedge clk);
    expect_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // Correct NOR gate: both builds pass; check timing landmarks.
    tt_r = NOR_TT;
    pulse_start();
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 2)  chk("s0_din_k2",  1, 32'(dut_in_s[1]), 32'd1);
      if (k == 4)  chk("s2_din_k4",  0, 32'(dut_in_s[0]), 32'd1);
      if (k == 14) chk("s0_din_k14", 1, 32'(dut_in_s[1]), 32'd7);
      if (k == 15) chk("s0_done15",  1, 32'(done_s[1]),   32'd0);
      if (k == 16) begin
        chk("s0_done16", 1, 32'(done_s[1]), 32'd1);
        chk("s0_pass16", 1, 32'(pass_s[1]), 32'd1);
      end
      if (k == 31) chk("nor_done31", 0, 32'(done_s[0]), 32'd0);
    end
    chk("nor_done", 0, 32'(done_s[0]), 32'd1);
    chk("nor_cap",  0, 32'(cap_s[0]),  32'h01);
    chk("nor_err",  0, 32'(err_s[0]),  32'd0);
    chk("nor_pass", 0, 32'(pass_s[0]), 32'd1);
    chk("nor_ffv",  0, 32'(ffv_s[0]),  32'd0);

    // Stuck-at-0 gate.
    tt_r = 8'h00;
    pulse_start();
    repeat (32) @(negedge clk);
    chk("sa0_cap",  0, 32'(cap_s[0]),  32'h00);
    chk("sa0_err",  0, 32'(err_s[0]),  32'd1);
    chk("sa0_ffi",  0, 32'(ffi_s[0]),  32'd0);
    chk("sa0_ffv",  0, 32'(ffv_s[0]),  32'd1);
    chk("sa0_pass", 0, 32'(pass_s[0]), 32'd0);

    // OR gate: every vector wrong.
    tt_r = 8'hFE;
    pulse_start();
    repeat (32) @(negedge clk);
    chk("or_cap",  0, 32'(cap_s[0]),  32'hFE);
    chk("or_err",  0, 32'(err_s[0]),  32'd8);
    chk("or_ffi",  0, 32'(ffi_s[0]),  32'd0);
    chk("or_pass", 0, 32'(pass_s[0]), 32'd0);

    // Asynchronous reset mid-sweep, then a clean sweep.
    tt_r = NOR_TT;
    pulse_start();
    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    #1 expect_cleared("midrst");
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    repeat (32) @(negedge clk);
    chk("rerun_done", 0, 32'(done_s[0]), 32'd1);
    chk("rerun_pass", 0, 32'(pass_s[0]), 32'd1);
    chk("rerun_cap",  0, 32'(cap_s[0]),  32'h01);

    // start while busy is ignored; start in DONE restarts at once.
    pulse_start();
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      start = (k == 4 || k == 19) ? 1'b1 : 1'b0;
      if (k == 31) chk("ign_done31", 0, 32'(done_s[0]), 32'd0);
    end
    start = 1'b0;
    chk("ign_done32", 0, 32'(done_s[0]), 32'd1);
    pulse_start();
    chk("restart_done", 0, 32'(done_s[0]), 32'd0);
    chk("restart_busy", 0, 32'(busy_s[0]), 32'd1);
    chk("restart_cap",  0, 32'(cap_s[0]),  32'h00);
    wait_both_done(200);

    // Randomized sweeps: random gates, stray starts, occasional resets.
    for (int it = 0; it < 40; it++) begin
      int n;
      int rc;
      bit do_rst;
      case ($urandom_range(0, 3))
        0:       tt_r = 8'h01;
        1:       tt_r = 8'h00;
        2:       tt_r = 8'hFE;
        default: tt_r = 8'($urandom);
      endcase
      do_rst = ($urandom_range(0, 4) == 0);
      rc     = $urandom_range(1, 30);
      pulse_start();
      n = 0;
      while (!(done_s[0] && done_s[1]) && n < 400) begin
        @(negedge clk);
        n++;
        if (do_rst && n == rc) begin
          start = 1'b0;
          #2 rst = 1'b1;
          @(negedge clk);
          rst    = 1'b0;
          do_rst = 1'b0;
          pulse_start();
        end else begin
          start = busy_s[0] && ($urandom_range(0, 9) == 0);
        end
      end
      start = 1'b0;
      chk("sweep_end", 0, 32'(done_s[0] && done_s[1]), 32'd1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
